// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encoding and controller state type.
package alu_pkg;

  localparam int   DATA_WIDTH  = 8;
  localparam int   ALU_OPCODES = 2;
  localparam logic ON          = 1'b1;
  localparam logic OFF         = 1'b0;

  localparam int CTRL_TIMEOUT_DEFAULT = 16;

  typedef enum logic [ALU_OPCODES-1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_PAR  = 2'd2,
    OP_COMP = 2'd3
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    STORE_A,
    STORE_B,
    START,
    RESP,
    RECOVER
  } ctrl_state_t;

endpackage

// File: rtl/alu_controller.sv
// Sequences one alu_datapath on behalf of a single requester: command in,
// operand/start strobes out, bounded wait for alu_done, response back.
module alu_controller
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CTRL_TIMEOUT_DEFAULT,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ALU_OPCODES-1:0] req_opcode,
  input  logic [DATA_WIDTH-1:0]  req_a,
  input  logic [DATA_WIDTH-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_timeout,
  output logic [DATA_WIDTH-1:0]  alu_data,
  output logic [ALU_OPCODES-1:0] opcode_value,
  output logic                   store_a,
  output logic                   store_b,
  output logic                   start,
  input  logic                   alu_done,
  input  logic [DATA_WIDTH-1:0]  result,
  input  logic                   overflow_def,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   op_count
);

  localparam int            TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ctrl_state_t           state, next_state;
  logic [TW-1:0]         to_cnt;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  accept, done_seen, timed_out;

  assign accept    = (state == IDLE) && req_valid;
  assign done_seen = (state == START) && alu_done;
  // alu_done takes priority over the last timeout cycle.
  assign timed_out = (state == START) && !alu_done && (to_cnt == TO_LAST);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = STORE_A;
      STORE_A: next_state = STORE_B;
      STORE_B: next_state = START;
      START:   if (done_seen || timed_out) next_state = RESP;
      RESP:    if (rsp_ready) next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign alu_data  = (state == STORE_A) ? a_q :
                     (state == STORE_B) ? b_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      to_cnt       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      opcode_value <= '0;
      store_a      <= OFF;
      store_b      <= OFF;
      start        <= OFF;
      rsp_valid    <= OFF;
      rsp_result   <= '0;
      rsp_overflow <= OFF;
      rsp_timeout  <= OFF;
      op_count     <= '0;
    end else begin
      state     <= next_state;
      // Strobes are registered from the next state so they align with it.
      store_a   <= (next_state == STORE_A);
      store_b   <= (next_state == STORE_B);
      start     <= (next_state == START);
      rsp_valid <= (next_state == RESP);

      if (state == START) to_cnt <= to_cnt + TW'(1);
      else                to_cnt <= '0;

      if (accept) begin
        opcode_value <= req_opcode;
        a_q          <= req_a;
        b_q          <= req_b;
      end

      if (done_seen) begin
        rsp_result   <= result;
        rsp_overflow <= overflow_def;
        rsp_timeout  <= OFF;
      end else if (timed_out) begin
        rsp_result   <= '0;
        rsp_overflow <= OFF;
        rsp_timeout  <= ON;
      end

      if ((state == RESP) && rsp_ready) op_count <= op_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller with a small behavioural datapath stub.
module tb_alu_controller;
  import alu_pkg::*;

  localparam int TO = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   req_valid, req_ready;
  logic [ALU_OPCODES-1:0] req_opcode;
  logic [DATA_WIDTH-1:0]  req_a, req_b;
  logic                   rsp_valid, rsp_ready;
  logic [DATA_WIDTH-1:0]  rsp_result;
  logic                   rsp_overflow, rsp_timeout;
  logic [DATA_WIDTH-1:0]  alu_data;
  logic [ALU_OPCODES-1:0] opcode_value;
  logic                   store_a, store_b, start;
  logic                   alu_done;
  logic [DATA_WIDTH-1:0]  result;
  logic                   overflow_def;
  logic                   busy;
  logic [15:0]            op_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_controller #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
    .alu_data(alu_data), .opcode_value(opcode_value),
    .store_a(store_a), .store_b(store_b), .start(start),
    .alu_done(alu_done), .result(result), .overflow_def(overflow_def),
    .busy(busy), .op_count(op_count)
  );

  // Datapath stub: latches operands, raises alu_done dp_lat cycles into start.
  logic stuck = 1'b0;
  int   dp_lat = 1;
  int   dp_cnt;
  logic [7:0] dp_a, dp_b;

  function automatic logic [8:0] dp_eval(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), a - b};
      OP_PAR:  return {8'h00, ^(a ^ b)};
      default: return {8'h00, (a > b)};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_done <= 1'b0; result <= '0; overflow_def <= 1'b0;
      dp_cnt <= 0; dp_a <= '0; dp_b <= '0;
    end else begin
      if (store_a) dp_a <= alu_data;
      if (store_b) dp_b <= alu_data;
      if (!start) begin
        alu_done <= 1'b0;
        dp_cnt   <= 0;
      end else if (!alu_done && !stuck) begin
        if (dp_cnt == dp_lat - 1) begin
          alu_done <= 1'b1;
          {overflow_def, result} <= dp_eval(opcode_value, dp_a, dp_b);
        end else begin
          dp_cnt <= dp_cnt + 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Issues one command from IDLE, returns the response and the cycle it appeared in.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic ovf, output logic to,
                        output int rsp_cyc);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    tick;
    req_valid = 1'b0;
    rsp_cyc = 1;
    while (!rsp_valid && rsp_cyc < 60) begin
      tick;
      rsp_cyc++;
    end
    check("rsp_wait", rsp_valid, 1);
    res = rsp_result; ovf = rsp_overflow; to = rsp_timeout;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res;
    logic       ovf, to;
    int         cyc, start_cyc, acc;
    logic       seen;
    logic [9:0] got[$];

    req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    #12;
    check("reset_ctl", {req_ready, busy, store_a, store_b, start, rsp_valid}, 6'b100000);
    check("reset_cnt", op_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // ADD 0F+01 with cycle-exact strobe checks
    req_valid = 1'b1; req_opcode = OP_ADD; req_a = 8'h0F; req_b = 8'h01;
    tick;
    req_valid = 1'b0;
    check("t1_c1", {req_ready, store_a, store_b, start}, 4'b0100);
    check("t1_c1_data", alu_data, 8'h0F);
    tick;
    check("t1_c2", {req_ready, store_a, store_b, start}, 4'b0010);
    check("t1_c2_data", alu_data, 8'h01);
    tick;
    check("t1_c3", {req_ready, store_a, store_b, start}, 4'b0001);
    check("t1_c3_data", {opcode_value, alu_data}, {OP_ADD, 8'h00});
    cyc = 3;
    while (!rsp_valid && cyc < 60) begin
      tick;
      cyc++;
    end
    check("t1_lat", cyc, 5);
    check("t1_rsp", {rsp_valid, start, rsp_result, rsp_overflow, rsp_timeout}, {2'b10, 8'h10, 2'b00});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("t1_recover", {rsp_valid, req_ready, busy}, 3'b001);
    check("t1_count", op_count, 1);
    tick;
    check("t1_idle", {req_ready, busy}, 2'b10);

    // ADD with carry out
    run_op(OP_ADD, 8'hFF, 8'h01, res, ovf, to, cyc);
    check("t2_rsp", {res, ovf, to}, {8'h00, 2'b10});
    check("t2_count", op_count, 2);

    // SUB with borrow, early rsp_ready ignored, then 5 cycles of back-pressure
    req_valid = 1'b1; req_opcode = OP_SUB; req_a = 8'h05; req_b = 8'h07;
    rsp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    rsp_ready = 1'b0;
    cyc = 2;
    while (!rsp_valid && cyc < 60) begin
      tick;
      cyc++;
    end
    check("t3_count_hold", op_count, 2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold%0d", i), {rsp_valid, req_ready, rsp_result, rsp_overflow, rsp_timeout},
            {2'b10, 8'hFE, 2'b10});
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    tick;
    check("t3_count", op_count, 3);

    // alu_done stuck low -> timeout
    stuck = 1'b1;
    req_valid = 1'b1; req_opcode = OP_ADD; req_a = 8'h11; req_b = 8'h22;
    tick;
    req_valid = 1'b0;
    cyc = 1; start_cyc = -1;
    while (!rsp_valid && cyc < 60) begin
      if (start && start_cyc < 0) start_cyc = cyc;
      tick;
      cyc++;
    end
    check("t4_start_cyc", start_cyc, 3);
    check("t4_gap", cyc - start_cyc, TO);
    check("t4_rsp", {rsp_valid, rsp_result, rsp_overflow, rsp_timeout}, {1'b1, 8'h00, 2'b01});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    tick;
    stuck = 1'b0;
    check("t4_count", op_count, 4);

    // alu_done in the last timeout cycle wins; one cycle later it loses
    dp_lat = 15;
    run_op(OP_ADD, 8'h11, 8'h22, res, ovf, to, cyc);
    check("t5_edge_win", {res, ovf, to}, {8'h33, 2'b00});
    check("t5_edge_cyc", cyc, 19);
    dp_lat = 16;
    run_op(OP_ADD, 8'h11, 8'h22, res, ovf, to, cyc);
    check("t5_edge_lose", {res, ovf, to}, {8'h00, 2'b01});
    check("t5_lose_cyc", cyc, 19);
    dp_lat = 1;

    // Asynchronous reset during START
    req_valid = 1'b1; req_opcode = OP_SUB; req_a = 8'h01; req_b = 8'h02;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    check("t6_in_start", start, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ctl", {req_ready, busy, store_a, store_b, start, rsp_valid}, 6'b100000);
    check("t6_async_dat", {alu_data, opcode_value, op_count}, 26'h0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen |= rsp_valid;
    end
    check("t6_no_rsp", seen, 0);
    check("t6_ready", req_ready, 1);

    // Back-to-back PAR then COMP with req_valid held and rsp_ready high
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_opcode = OP_PAR; req_a = 8'h03; req_b = 8'h01;
    tick;
    req_opcode = OP_COMP; req_a = 8'h04; req_b = 8'h09;
    acc = -1;
    for (int c = 1; c < 40; c++) begin
      if (rsp_valid) got.push_back({rsp_overflow, rsp_timeout, rsp_result});
      if (req_valid && req_ready && acc < 0) acc = c;
      tick;
      if (acc >= 0 && c == acc) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    check("t7_accept_cyc", acc, 7);
    check("t7_nrsp", got.size(), 2);
    check("t7_rsp0", (got.size() > 0) ? got[0] : 10'bx, {2'b00, 8'h01});
    check("t7_rsp1", (got.size() > 1) ? got[1] : 10'bx, {2'b00, 8'h00});
    check("t7_count", op_count, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
